// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding,
// default operand width and the iteration-counter width helper.
package div_seq_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter must hold WIDTH-1; keep at least one bit for degenerate widths.
    function automatic int div_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder, trial-subtracts the divisor magnitude and selects.
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_quo_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_unused_top;

    // The remainder never reaches 2^WIDTH, so its top bit carries no information
    // into the shift; the trial sign bit is still exact at WIDTH+1 bits.
    assign w_unused_top = i_rem[WIDTH];
    assign w_shift      = {i_rem[WIDTH-1:0], i_quo_msb};
    assign w_trial      = w_shift - {1'b0, i_divisor};
    assign o_qbit       = ~w_trial[WIDTH];
    assign o_rem        = o_qbit ? w_trial : w_shift;

endmodule

// File: rtl/div_seq.sv
// Multicycle signed divider (truncating quotient, fixed WIDTH+2 cycle latency).
// Optional signed remainder output is built when DIV_REMAINDER_EN is defined.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_busy
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_absb;
    logic             r_sign_q;
    logic             r_divzero;
    logic             w_qbit;
    logic             w_start;
    logic             w_fix;
`ifdef DIV_REMAINDER_EN
    logic             r_sign_r;
`endif

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] f_magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] mag,
                                                      input logic             neg);
        return neg ? -mag : mag;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo_msb (r_quo[WIDTH-1]),
        .i_divisor (r_absb),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_start        = 1'b0;
        w_fix          = 1'b0;
        data_busy      = 1'b0;
        data_resultRDY = 1'b0;
        case (r_state)
            IDLE: begin
                if (ctrl_div) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                data_busy = 1'b1;
                if (r_cnt == '0) w_state_nxt = FIX;
            end
            FIX: begin
                data_busy   = 1'b1;
                w_fix       = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                if (ctrl_div) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt <= CNT_W'(WIDTH - 1);
            end else if (r_state == RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_fix) begin
                data_result    <= r_divzero ? '0 : f_apply_sign(r_quo, r_sign_q);
                data_exception <= r_divzero;
`ifdef DIV_REMAINDER_EN
                data_remainder <= r_divzero ? '0 : f_apply_sign(r_rem[WIDTH-1:0], r_sign_r);
`endif
            end
        end
    end

    // Datapath needs no reset: it is fully reloaded on every accepted start.
    always_ff @(posedge clock) begin
        if (w_start) begin
            r_rem     <= '0;
            r_quo     <= f_magnitude(data_operandA);
            r_absb    <= f_magnitude(data_operandB);
            r_sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_divzero <= (data_operandB == '0);
`ifdef DIV_REMAINDER_EN
            r_sign_r  <= data_operandA[WIDTH-1];
`endif
        end else if (r_state == RUN) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed vector table, multi-cycle corner sequences
// and randomized operands against a plain-arithmetic reference model.
module tb_div_seq;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int n_checks = 0;
    int n_errors = 0;

    div_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .data_busy      (data_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        exc;
        logic [31:0] rem;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division done in 64-bit arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint la, lb, lq, lr;
        la = longint'(signed'(a));
        lb = longint'(signed'(b));
        if (lb == 0) begin
            q = '0;
            r = '0;
            e = 1'b1;
        end else begin
            lq = la / lb;
            lr = la % lb;
            q  = lq[31:0];
            r  = lr[31:0];
            e  = 1'b0;
        end
    endtask

    task automatic start_now(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_div      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic count_rdy(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] q,
                                 input logic e, input logic [31:0] r);
        chk({tag, "_result"}, data_result, q);
        chk({tag, "_exception"}, 32'(data_exception), 32'(e));
`ifdef DIV_REMAINDER_EN
        chk({tag, "_remainder"}, data_remainder, r);
`else
        if (r === 32'hx) $display("note: undefined remainder expectation");
`endif
    endtask

    initial begin
        int          k;
        int          pulses;
        logic [31:0] ra, rb, eq, er;
        logic        ee;

        tbl[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         exc: 1'b0, rem: 32'd2};
        tbl[1]  = '{a: 32'hFFFFFF9C,   b: 32'd7,          q: 32'hFFFFFFF2,   exc: 1'b0, rem: 32'hFFFFFFFE};
        tbl[2]  = '{a: 32'd5,          b: 32'd0,          q: 32'd0,          exc: 1'b1, rem: 32'd0};
        tbl[3]  = '{a: 32'd6,          b: 32'd3,          q: 32'd2,          exc: 1'b0, rem: 32'd0};
        tbl[4]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'h80000000,   exc: 1'b0, rem: 32'd0};
        tbl[5]  = '{a: 32'h80000000,   b: 32'd1,          q: 32'h80000000,   exc: 1'b0, rem: 32'd0};
        tbl[6]  = '{a: 32'd7,          b: 32'hFFFFFFFE,   q: 32'hFFFFFFFD,   exc: 1'b0, rem: 32'd1};
        tbl[7]  = '{a: 32'hFFFFFFF9,   b: 32'hFFFFFFFE,   q: 32'd3,          exc: 1'b0, rem: 32'hFFFFFFFF};
        tbl[8]  = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          exc: 1'b0, rem: 32'd0};
        tbl[9]  = '{a: 32'hFFFFFFFF,   b: 32'h80000000,   q: 32'd0,          exc: 1'b0, rem: 32'hFFFFFFFF};
        tbl[10] = '{a: 32'h7FFFFFFF,   b: 32'h7FFFFFFF,   q: 32'd1,          exc: 1'b0, rem: 32'd0};

        reset_n       = 1'b1;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #2 reset_n = 1'b0;
        #1;
        check_outputs("reset", 32'd0, 1'b0, 32'd0);
        chk("reset_rdy", 32'(data_resultRDY), 32'd0);
        chk("reset_busy", 32'(data_busy), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            start_now(tbl[i].a, tbl[i].b);
            chk($sformatf("v%0d_busy_after_start", i), 32'(data_busy), 32'd1);
            wait_rdy(k);
            chk($sformatf("v%0d_latency", i), 32'(k), 32'd33);
            chk($sformatf("v%0d_busy_in_rdy", i), 32'(data_busy), 32'd0);
            check_outputs($sformatf("v%0d", i), tbl[i].q, tbl[i].exc, tbl[i].rem);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_rdy_one_cycle", i), 32'(data_resultRDY), 32'd0);
            check_outputs($sformatf("v%0d_hold", i), tbl[i].q, tbl[i].exc, tbl[i].rem);
        end

        // Start during RUN is ignored; start in the ready cycle runs immediately
        @(negedge clock);
        start_now(32'd40, 32'd8);
        repeat (9) @(posedge clock);
        #1;
        start_now(32'd9, 32'd3);
        wait_rdy(k);
        chk("ignored_start_latency", 32'(k), 32'd23);
        check_outputs("ignored_start", 32'd5, 1'b0, 32'd0);
        start_now(32'd9, 32'd3);
        chk("b2b_busy", 32'(data_busy), 32'd1);
        wait_rdy(k);
        chk("b2b_latency", 32'(k), 32'd33);
        check_outputs("b2b", 32'd3, 1'b0, 32'd0);
        count_rdy(40, pulses);
        chk("no_queued_start", 32'(pulses), 32'd0);

        // Asynchronous reset during a division
        @(negedge clock);
        start_now(32'd1000, 32'd10);
        repeat (14) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_outputs("midreset", 32'd0, 1'b0, 32'd0);
        chk("midreset_busy", 32'(data_busy), 32'd0);
        chk("midreset_rdy", 32'(data_resultRDY), 32'd0);
        #2 reset_n = 1'b1;
        count_rdy(40, pulses);
        chk("midreset_no_rdy", 32'(pulses), 32'd0);
        @(negedge clock);
        start_now(32'd1000, 32'd10);
        wait_rdy(k);
        chk("after_reset_latency", 32'(k), 32'd33);
        check_outputs("after_reset", 32'd100, 1'b0, 32'd0);

        // Randomized operands against the reference model
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 1000));
                default: ;
            endcase
            model(ra, rb, eq, er, ee);
            @(negedge clock);
            start_now(ra, rb);
            wait_rdy(k);
            chk($sformatf("rnd%0d_latency", n), 32'(k), 32'd33);
            check_outputs($sformatf("rnd%0d_%08h_%08h", n, ra, rb), eq, ee, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
